// File: rtl/batch_controller_pkg.sv
// Shared types and default sizes for the batch sequencer.
package batch_controller_pkg;

  localparam int unsigned DEF_GROUP_SIZE = 8;
  localparam int unsigned DEF_IDX_W      = 3;
  localparam int unsigned DEF_ADDR_W     = 6;
  localparam int unsigned DEF_CNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOAD   = 3'd2,
    OP     = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } state_t;

endpackage

// File: rtl/batch_controller_group_counter.sv
// Loadable up-counter with terminal-count flag; a limit of 0 means the full 2**W range.
module group_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + W'(1);
  end

  // limit-1 wraps to all ones when limit is 0, giving the full-range terminal count.
  assign last = (count == limit - W'(1));

endmodule

// File: rtl/batch_controller.sv
// Sequencer: input memory -> register file -> operation unit -> output memory, in 8-word groups.
module batch_controller
  import batch_controller_pkg::*;
#(
  parameter int unsigned GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_groups,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] AddrReading,
  output logic [ADDR_W-1:0] AddrWriting,
  output logic [IDX_W-1:0]  RegIndex,
  output logic              EnableInputMEM,
  output logic              EnableReg,
  output logic              EnableOperation,
  output logic              EnableOutputMEM,
  output logic              Busy,
  output logic              Done
);

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  numGroupsQ;
  logic [CNT_W-1:0]  groupCount;
  logic              lastGroup;
  logic              lastReg;
  logic              accept;
  logic              nextGroup;

  assign accept    = start && ((state == IDLE) || (state == FINISH));
  assign nextGroup = (state == WRITE) && out_ready && !lastGroup;

  group_counter #(.W(CNT_W)) uGroupCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .inc   (nextGroup),
    .limit (numGroupsQ),
    .count (groupCount),
    .last  (lastGroup)
  );

  group_counter #(.W(IDX_W)) uRegCnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || nextGroup),
    .inc   ((state == LOAD) && !lastReg),
    .limit (IDX_W'(GROUP_SIZE)),
    .count (RegIndex),
    .last  (lastReg)
  );

  // Write address advances and clears exactly with the group counter, so it is the group index.
  assign AddrWriting = ADDR_W'(groupCount);

  // State, read address and latched group count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      AddrReading <= '0;
      numGroupsQ  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        AddrReading <= '0;
        numGroupsQ  <= num_groups;
      end else if (state == LOAD) begin
        AddrReading <= AddrReading + ADDR_W'(1);
      end
    end
  end

  // Next-state and decoded enables/status.
  always_comb begin
    stateNext       = state;
    EnableInputMEM  = 1'b0;
    EnableReg       = 1'b0;
    EnableOperation = 1'b0;
    EnableOutputMEM = 1'b0;
    Busy            = 1'b0;
    Done            = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) stateNext = READ;
      end
      READ: begin
        EnableInputMEM = 1'b1;
        Busy           = 1'b1;
        stateNext      = LOAD;
      end
      LOAD: begin
        EnableReg = 1'b1;
        Busy      = 1'b1;
        stateNext = lastReg ? OP : READ;
      end
      OP: begin
        EnableOperation = 1'b1;
        Busy            = 1'b1;
        stateNext       = WRITE;
      end
      WRITE: begin
        EnableOutputMEM = 1'b1;
        Busy            = 1'b1;
        if (out_ready) stateNext = lastGroup ? FINISH : READ;
      end
      FINISH: begin
        Done = 1'b1;
        if (start) stateNext = READ;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/batch_controller.md
Name: batch_controller

Overview:
- Sequencer for the input-memory → register-file → operation-unit → output-memory datapath.
- On a `start` pulse, runs a programmable number of 8-word groups.
- For each group: loads 8 words into the register file, fires one operation, writes one result word.
- Adds a start/busy/done handshake and output-memory back-pressure (`out_ready`), so a host can launch batches repeatedly without a reset.

Parameters:
- GROUP_SIZE, 8, words loaded per group; must equal 2**IDX_W.
- IDX_W, 3, width of RegIndex.
- ADDR_W, 6, width of read/write addresses.
- CNT_W, 3, width of the group counter and num_groups; 2**CNT_W * GROUP_SIZE must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE or FINISH.
- num_groups  in  CNT_W  groups per batch; latched when start is accepted; 0 means 2**CNT_W (8).
- out_ready  in  1  output memory accepts the write this cycle.
- AddrReading  out  ADDR_W  input-memory read address.
- AddrWriting  out  ADDR_W  output-memory write address.
- RegIndex  out  IDX_W  register-file slot being loaded.
- EnableInputMEM  out  1  input-memory read enable.
- EnableReg  out  1  register-file write enable.
- EnableOperation  out  1  operation-unit fire.
- EnableOutputMEM  out  1  output-memory write request.
- Busy  out  1  batch in progress.
- Done  out  1  batch complete.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; AddrReading, AddrWriting, RegIndex, group counter, latched count all 0; all enables, Busy and Done 0.
- Enables, Busy and Done are combinational decodes of the registered state. Addresses and RegIndex are registered.
- States: IDLE, READ, LOAD, OP, WRITE, FINISH.
- IDLE / FINISH:
  - start=1 → READ.
  - On that edge: latch num_groups; clear AddrReading, AddrWriting, RegIndex and the group counter.
  - Otherwise hold the current state.
- READ: EnableInputMEM=1 → LOAD. Memory data is valid in the following cycle.
- LOAD: EnableReg=1; AddrReading+=1 (wraps mod 2**ADDR_W).
  - RegIndex < GROUP_SIZE-1 → RegIndex+=1, go to READ.
  - Else → OP; RegIndex holds GROUP_SIZE-1.
- OP: EnableOperation=1 → WRITE.
- WRITE: EnableOutputMEM=1 and AddrWriting held stable while out_ready=0 (unbounded stall). When out_ready=1:
  - Last group → FINISH.
  - Otherwise group counter+=1, AddrWriting+=1, RegIndex=0, go to READ.
- FINISH: Done=1 (level, held until the next accepted start); Busy=0.
- Busy=1 in READ, LOAD, OP and WRITE.
- start while Busy=1 is ignored; it is not queued.
- Group latency with out_ready=1: 18 cycles (8×READ/LOAD = 16, OP 1, WRITE 1).
- After a batch of N groups: AddrReading = 8N mod 64 (N=8 gives 0); AddrWriting = N-1; both held in FINISH.
- rst asserted mid-batch: immediate return to reset values; no further enables; Done stays 0.
- Only one enable is active in any cycle (one-hot across the four enables).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, READ=1, LOAD=2, OP=3, WRITE=4, FINISH=5);
  - GROUP_SIZE, IDX_W, ADDR_W, CNT_W defaults.
- Sub-module `group_counter`: loadable up-counter with terminal-count compare against the latched num_groups (0 ⇒ full range). It is reused for RegIndex with a constant limit.
- Everything else stays in the single FSM module.

Test Plan:
- Reset, then start=1 one cycle, num_groups=1, out_ready=1.
  - Expect 8 READ/LOAD pairs with AddrReading 0..7 and RegIndex 0..7.
  - Then OP, then one WRITE at AddrWriting=0.
  - Done=1 exactly 18 cycles after the start-sampling edge; AddrReading=8.
- num_groups=0, out_ready=1.
  - Expect 8 writes at AddrWriting 0..7.
  - Done 144 cycles after start; AddrReading wraps to 0.
- num_groups=2, out_ready low for 5 cycles in the first WRITE.
  - EnableOutputMEM and AddrWriting=0 held for 6 cycles.
  - Done at 41 cycles.
- start re-pulsed during LOAD of group 0.
  - Ignored: sequence and Done timing are unchanged vs. scenario 1.
  - Second start in FINISH: Done drops next cycle, addresses restart from 0.
- rst asserted in OP of group 1 (num_groups=3).
  - All outputs 0 within the same cycle (asynchronous).
  - After release, state is IDLE with no enables until a new start.
- Every scenario: assertion that at most one enable is high per cycle, and Busy == !(IDLE || FINISH).
